pulse_param_loader: RTL and testbench

- Upstream stage of the pulse generator. Assembles one pulse-parameter frame from bytes delivered by the UART receiver and verifies its checksum.
- On a good frame, updates the whole parameter bus in one cycle and raises a load strobe. The pulse generator samples this strobe through its two-flop synchroniser on the same clk.
- Bad or abandoned frames leave the outputs untouched.

---
 rtl/pulse_param_pkg.sv | 89 ++++++++
 rtl/pulse_param_loader_if.sv | 11 +
 rtl/pulse_param_loader_strobe_stretch.sv | 32 +++
 rtl/pulse_param_loader.sv | 127 ++++++++++++
 tb/tb_pulse_param_loader.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_param_pkg.sv
// Shared constants, frame layout and parameter record for the pulse-parameter loader.
// Field defaults here are what the pulse generator runs with until the first good frame.
package pulse_param_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         PAYLOAD_LEN = 17;
  localparam int         IDX_W       = $clog2(PAYLOAD_LEN);

  // Byte offsets inside the payload; multi-byte fields are sent MSB first.
  localparam int OFF_PER      = 0;
  localparam int OFF_P1WID    = 3;
  localparam int OFF_DEL      = 5;
  localparam int OFF_P2WID    = 7;
  localparam int OFF_NUT_W    = 9;
  localparam int OFF_NUT_D    = 10;
  localparam int OFF_FLAGS    = 12;
  localparam int OFF_CP       = 13;
  localparam int OFF_P_BL     = 14;
  localparam int OFF_P_BL_OFF = 15;

  localparam logic [23:0] PER_RST      = 24'h010000;
  localparam logic [15:0] P1WID_RST    = 16'd30;
  localparam logic [15:0] DEL_RST      = 16'd200;
  localparam logic [15:0] P2WID_RST    = 16'd30;
  localparam logic [7:0]  NUT_W_RST    = 8'd50;
  localparam logic [15:0] NUT_D_RST    = 16'd300;
  localparam logic        NUT_RST      = 1'b1;
  localparam logic        PU_RST       = 1'b1;
  localparam logic        BL_RST       = 1'b1;
  localparam logic [7:0]  CP_RST       = 8'd3;
  localparam logic [7:0]  P_BL_RST     = 8'd50;
  localparam logic [15:0] P_BL_OFF_RST = 16'd100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_CSUM
  } state_t;

  typedef logic [PAYLOAD_LEN-1:0][7:0] payload_t;

  typedef struct packed {
    logic [23:0] per;
    logic [15:0] p1wid;
    logic [15:0] del;
    logic [15:0] p2wid;
    logic [7:0]  nut_w;
    logic [15:0] nut_d;
    logic        nut;
    logic        pu;
    logic        bl;
    logic [7:0]  cp;
    logic [7:0]  p_bl;
    logic [15:0] p_bl_off;
  } params_t;

  localparam params_t PARAMS_RST = '{
    per:      PER_RST,
    p1wid:    P1WID_RST,
    del:      DEL_RST,
    p2wid:    P2WID_RST,
    nut_w:    NUT_W_RST,
    nut_d:    NUT_D_RST,
    nut:      NUT_RST,
    pu:       PU_RST,
    bl:       BL_RST,
    cp:       CP_RST,
    p_bl:     P_BL_RST,
    p_bl_off: P_BL_OFF_RST
  };

  function automatic params_t unpack_payload(input payload_t p);
    params_t r;
    r.per      = {p[OFF_PER], p[OFF_PER+1], p[OFF_PER+2]};
    r.p1wid    = {p[OFF_P1WID], p[OFF_P1WID+1]};
    r.del      = {p[OFF_DEL], p[OFF_DEL+1]};
    r.p2wid    = {p[OFF_P2WID], p[OFF_P2WID+1]};
    r.nut_w    = p[OFF_NUT_W];
    r.nut_d    = {p[OFF_NUT_D], p[OFF_NUT_D+1]};
    r.pu       = p[OFF_FLAGS][0];
    r.nut      = p[OFF_FLAGS][1];
    r.bl       = p[OFF_FLAGS][2];
    r.cp       = p[OFF_CP];
    r.p_bl     = p[OFF_P_BL];
    r.p_bl_off = {p[OFF_P_BL_OFF], p[OFF_P_BL_OFF+1]};
    return r;
  endfunction

endpackage

// File: rtl/pulse_param_loader_if.sv
// Byte stream from the UART receiver into the parameter loader.
interface pulse_param_loader_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;

  modport master (output rx_data, rx_valid, rx_err);
  modport slave  (input  rx_data, rx_valid, rx_err);

endinterface

// File: rtl/pulse_param_loader_strobe_stretch.sv
// Restartable pulse stretcher: a trigger holds stb high for STB_CYCLES cycles,
// and a new trigger while high restarts the count so the strobe never drops.
module strobe_stretch #(
  parameter int STB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic trig,
  output logic stb
);

  localparam int CNT_W = 4;

  logic [CNT_W-1:0] remain;

  // NOTE: non-blocking assignments throughout so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remain <= '0;
      stb    <= 1'b0;
    end else if (trig) begin
      remain <= CNT_W'(STB_CYCLES - 1);
      stb    <= 1'b1;
    end else if (remain != '0) begin
      remain <= remain - CNT_W'(1);
      stb    <= 1'b1;
    end else begin
      stb    <= 1'b0;
    end
  end

endmodule

// File: rtl/pulse_param_loader.sv
// Assembles a SYNC + 17-byte + checksum frame from the UART and, on a good checksum,
// commits the whole parameter set in one cycle and raises load_stb for the generator.
module pulse_param_loader
  import pulse_param_pkg::*;
#(
  parameter int TIMEOUT    = 2000,
  parameter int STB_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  pulse_param_loader_if.slave  rx,
  output logic [23:0]          per,
  output logic [15:0]          p1wid,
  output logic [15:0]          del,
  output logic [15:0]          p2wid,
  output logic [7:0]           nut_w,
  output logic [15:0]          nut_d,
  output logic                 nut,
  output logic                 pu,
  output logic                 bl,
  output logic [7:0]           cp,
  output logic [7:0]           p_bl,
  output logic [15:0]          p_bl_off,
  output logic                 load_stb,
  output logic                 csum_err,
  output logic                 tmo_err,
  output logic [7:0]           good_cnt
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       sum;
  logic [TMO_W-1:0] tmo_cnt;
  payload_t         staging;
  params_t          params_q;

  logic in_frame;
  logic tmo_hit;
  logic commit;

  assign in_frame = (state != ST_IDLE);
  // A byte arriving in the last allowed cycle still counts; only true silence expires.
  assign tmo_hit  = in_frame && !rx.rx_valid && (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign commit   = (state == ST_CSUM) && rx.rx_valid && !rx.rx_err && (rx.rx_data == sum);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      idx      <= '0;
      sum      <= '0;
      tmo_cnt  <= '0;
      // NOTE: the staging buffer is reset on purpose so a partial frame never survives reset.
      staging  <= '0;
      params_q <= PARAMS_RST;
      csum_err <= 1'b0;
      tmo_err  <= 1'b0;
      good_cnt <= '0;
    end else begin
      csum_err <= 1'b0;
      tmo_err  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (rx.rx_valid && rx.rx_data == SYNC_BYTE) begin
            state   <= ST_PAYLOAD;
            idx     <= '0;
            sum     <= '0;
            tmo_cnt <= '0;
          end
        end
        ST_PAYLOAD, ST_CSUM: begin
          if (rx.rx_err || tmo_hit) begin
            tmo_err <= 1'b1;
            state   <= ST_IDLE;
          end else if (rx.rx_valid) begin
            tmo_cnt <= '0;
            if (state == ST_PAYLOAD) begin
              staging[idx] <= rx.rx_data;
              sum          <= sum + rx.rx_data;
              idx          <= idx + IDX_W'(1);
              if (idx == IDX_W'(PAYLOAD_LEN - 1)) state <= ST_CSUM;
            end else begin
              if (commit) begin
                params_q <= unpack_payload(staging);
                good_cnt <= good_cnt + 8'd1;
              end else begin
                csum_err <= 1'b1;
              end
              state <= ST_IDLE;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Flag bits 7:3 are carried in the checksum but drive nothing.
  logic unused_flag_bits;
  assign unused_flag_bits = ^staging[OFF_FLAGS][7:3];

  strobe_stretch #(
    .STB_CYCLES (STB_CYCLES)
  ) u_strobe_stretch (
    .clk   (clk),
    .reset (reset),
    .trig  (commit),
    .stb   (load_stb)
  );

  assign per      = params_q.per;
  assign p1wid    = params_q.p1wid;
  assign del      = params_q.del;
  assign p2wid    = params_q.p2wid;
  assign nut_w    = params_q.nut_w;
  assign nut_d    = params_q.nut_d;
  assign nut      = params_q.nut;
  assign pu       = params_q.pu;
  assign bl       = params_q.bl;
  assign cp       = params_q.cp;
  assign p_bl     = params_q.p_bl;
  assign p_bl_off = params_q.p_bl_off;

endmodule

// File: tb/tb_pulse_param_loader.sv
// Self-checking bench for pulse_param_loader: frames are modelled as byte arrays and
// the expected parameter set is the last payload whose byte sum matched its checksum.
module tb_pulse_param_loader;

  localparam int         TIMEOUT    = 2000;
  localparam int         STB_CYCLES = 4;
  localparam logic [7:0] SYNC       = 8'hA5;

  typedef logic [7:0] frame_t [17];

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pulse_param_loader_if rx_bus ();

  logic [23:0] per;
  logic [15:0] p1wid, del, p2wid, nut_d, p_bl_off;
  logic [7:0]  nut_w, cp, p_bl, good_cnt;
  logic        nut, pu, bl, load_stb, csum_err, tmo_err;

  pulse_param_loader #(
    .TIMEOUT    (TIMEOUT),
    .STB_CYCLES (STB_CYCLES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx_bus.slave),
    .per      (per),
    .p1wid    (p1wid),
    .del      (del),
    .p2wid    (p2wid),
    .nut_w    (nut_w),
    .nut_d    (nut_d),
    .nut      (nut),
    .pu       (pu),
    .bl       (bl),
    .cp       (cp),
    .p_bl     (p_bl),
    .p_bl_off (p_bl_off),
    .load_stb (load_stb),
    .csum_err (csum_err),
    .tmo_err  (tmo_err),
    .good_cnt (good_cnt)
  );

  logic s_trig = 1'b0;
  logic s_stb;

  strobe_stretch #(
    .STB_CYCLES (STB_CYCLES)
  ) u_stretch (
    .clk   (clk),
    .reset (reset),
    .trig  (s_trig),
    .stb   (s_stb)
  );

  int n_checks = 0;
  int n_errors = 0;

  frame_t     reset_frame = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h1E, 8'h00, 8'hC8, 8'h00, 8'h1E,
                              8'h32, 8'h01, 8'h2C, 8'h07, 8'h03, 8'h32, 8'h00, 8'h64};
  frame_t     plan_frame  = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h28, 8'h00, 8'h64, 8'h00, 8'h28,
                              8'h20, 8'h01, 8'h00, 8'h05, 8'h01, 8'h10, 8'h00, 8'h80};
  frame_t     exp_frame;
  logic [7:0] exp_good;

  logic [135:0] dut_vec;
  assign dut_vec = {per, p1wid, del, p2wid, nut_w, nut_d, 5'b0, bl, nut, pu, cp, p_bl, p_bl_off};

  // Output vector implied by a payload: bytes in order, flags reduced to their three used bits.
  function automatic logic [135:0] model_vec(input frame_t f);
    logic [135:0] v = '0;
    for (int i = 0; i < 17; i++) v = {v[127:0], (i == 12) ? {5'b0, f[i][2:0]} : f[i]};
    return v;
  endfunction

  function automatic logic [7:0] model_sum(input frame_t f);
    int s = 0;
    for (int i = 0; i < 17; i++) s += int'(f[i]);
    return 8'(s % 256);
  endfunction

  function automatic frame_t random_frame();
    frame_t f;
    for (int i = 0; i < 17; i++) f[i] = 8'($urandom);
    return f;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_bus.rx_data  = b;
    rx_bus.rx_valid = 1'b1;
    @(negedge clk);
    rx_bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_partial(input frame_t f, input int n, input int max_gap);
    send_byte(SYNC);
    for (int i = 0; i < n; i++) begin
      idle(int'($urandom_range(max_gap, 0)));
      send_byte(f[i]);
    end
  endtask

  task automatic send_frame(input frame_t f, input logic [7:0] csum, input int max_gap);
    send_partial(f, 17, max_gap);
    idle(int'($urandom_range(max_gap, 0)));
    send_byte(csum);
  endtask

  task automatic test_reset();
    rx_bus.rx_data  = 8'h00;
    rx_bus.rx_valid = 1'b0;
    rx_bus.rx_err   = 1'b0;
    reset = 1'b0;
    idle(3);
    n_checks++;
    if (dut_vec !== model_vec(reset_frame)) begin
      n_errors++; $display("FAIL reset_params: got %h expected %h", dut_vec, model_vec(reset_frame));
    end
    n_checks++;
    if ({load_stb, csum_err, tmo_err, good_cnt} !== 11'd0) begin
      n_errors++; $display("FAIL reset_flags: got stb=%b ce=%b te=%b cnt=%0d expected all 0",
                           load_stb, csum_err, tmo_err, good_cnt);
    end
    reset = 1'b1;
    idle(1);
    exp_frame = reset_frame;
    exp_good  = 8'd0;
  endtask

  task automatic test_bad_checksum();
    int pulses = 0;
    int stb_hi = 0;
    send_frame(plan_frame, model_sum(plan_frame) + 8'd1, 0);
    n_checks++;
    if (csum_err !== 1'b1) begin
      n_errors++; $display("FAIL bad_csum_pulse: got %b expected 1", csum_err);
    end
    for (int i = 0; i < 8; i++) begin
      pulses += int'(csum_err);
      stb_hi += int'(load_stb);
      @(negedge clk);
    end
    n_checks++;
    if (pulses != 1 || stb_hi != 0) begin
      n_errors++; $display("FAIL bad_csum_width: got %0d csum_err cycles, %0d load_stb cycles expected 1 and 0",
                           pulses, stb_hi);
    end
    n_checks++;
    if (dut_vec !== model_vec(exp_frame) || good_cnt !== exp_good) begin
      n_errors++; $display("FAIL bad_csum_hold: got %h cnt=%0d expected %h cnt=%0d",
                           dut_vec, good_cnt, model_vec(exp_frame), exp_good);
    end
  endtask

  task automatic test_good_frame();
    logic [7:0] pat;
    logic [7:0] pat_exp;
    send_partial(plan_frame, 17, 0);
    n_checks++;
    if (dut_vec !== model_vec(exp_frame) || load_stb !== 1'b0) begin
      n_errors++; $display("FAIL good_before_commit: got %h stb=%b expected %h stb=0",
                           dut_vec, load_stb, model_vec(exp_frame));
    end
    send_byte(model_sum(plan_frame));
    exp_frame = plan_frame;
    exp_good  = exp_good + 8'd1;
    n_checks++;
    if (dut_vec !== model_vec(exp_frame)) begin
      n_errors++; $display("FAIL good_params: got %h expected %h", dut_vec, model_vec(exp_frame));
    end
    n_checks++;
    if ({nut, pu, bl} !== 3'b011) begin
      n_errors++; $display("FAIL good_flags: got nut=%b pu=%b bl=%b expected nut=0 pu=1 bl=1", nut, pu, bl);
    end
    n_checks++;
    if (good_cnt !== exp_good) begin
      n_errors++; $display("FAIL good_cnt: got %0d expected %0d", good_cnt, exp_good);
    end
    for (int i = 0; i < 8; i++) begin
      pat[i]     = load_stb;
      pat_exp[i] = (i < STB_CYCLES);
      @(negedge clk);
    end
    n_checks++;
    if (pat !== pat_exp) begin
      n_errors++; $display("FAIL good_stb_shape: got %b expected %b", pat, pat_exp);
    end
  endtask

  task automatic test_timeout();
    frame_t f;
    int waited = 0;
    f = random_frame();
    send_partial(f, 5, 0);
    while (tmo_err !== 1'b1 && waited < TIMEOUT + 50) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (tmo_err !== 1'b1 || waited < TIMEOUT - 1 || waited > TIMEOUT + 1) begin
      n_errors++; $display("FAIL tmo_silence: got tmo_err=%b after %0d cycles expected 1 after about %0d",
                           tmo_err, waited, TIMEOUT);
    end
    @(negedge clk);
    n_checks++;
    if (tmo_err !== 1'b0 || dut_vec !== model_vec(exp_frame)) begin
      n_errors++; $display("FAIL tmo_after: got tmo_err=%b params %h expected 0 and %h",
                           tmo_err, dut_vec, model_vec(exp_frame));
    end
    send_partial(random_frame(), 8, 1);
    rx_bus.rx_err = 1'b1;
    send_byte(8'h3C);
    rx_bus.rx_err = 1'b0;
    n_checks++;
    if (tmo_err !== 1'b1) begin
      n_errors++; $display("FAIL rx_err_abort: got tmo_err=%b expected 1", tmo_err);
    end
    idle(2);
    rx_bus.rx_err = 1'b1;
    @(negedge clk);
    rx_bus.rx_err = 1'b0;
    n_checks++;
    if (tmo_err !== 1'b0) begin
      n_errors++; $display("FAIL rx_err_idle: got tmo_err=%b expected 0", tmo_err);
    end
    f = random_frame();
    send_frame(f, model_sum(f), 2);
    exp_frame = f;
    exp_good  = exp_good + 8'd1;
    n_checks++;
    if (dut_vec !== model_vec(exp_frame) || good_cnt !== exp_good) begin
      n_errors++; $display("FAIL tmo_recover: got %h cnt=%0d expected %h cnt=%0d",
                           dut_vec, good_cnt, model_vec(exp_frame), exp_good);
    end
  endtask

  task automatic test_garbage();
    frame_t     f;
    logic [7:0] g;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    for (int i = 0; i < 5; i++) begin
      g = 8'($urandom);
      if (g == SYNC) g = 8'h00;
      send_byte(g);
    end
    n_checks++;
    if (good_cnt !== exp_good || csum_err !== 1'b0) begin
      n_errors++; $display("FAIL garbage_ignored: got cnt=%0d ce=%b expected cnt=%0d ce=0",
                           good_cnt, csum_err, exp_good);
    end
    f = random_frame();
    send_frame(f, model_sum(f), 0);
    exp_frame = f;
    exp_good  = exp_good + 8'd1;
    n_checks++;
    if (dut_vec !== model_vec(exp_frame) || good_cnt !== exp_good) begin
      n_errors++; $display("FAIL garbage_commit: got %h cnt=%0d expected %h cnt=%0d",
                           dut_vec, good_cnt, model_vec(exp_frame), exp_good);
    end
  endtask

  task automatic test_random_frames();
    frame_t     f;
    logic       bad;
    logic [7:0] csum;
    for (int n = 0; n < 8; n++) begin
      f    = random_frame();
      bad  = ($urandom_range(2, 0) == 0);
      csum = model_sum(f) + (bad ? 8'($urandom_range(255, 1)) : 8'd0);
      send_frame(f, csum, 3);
      if (!bad) begin
        exp_frame = f;
        exp_good  = exp_good + 8'd1;
      end
      n_checks++;
      if (csum_err !== bad || dut_vec !== model_vec(exp_frame) || good_cnt !== exp_good) begin
        n_errors++; $display("FAIL random_frame_%0d: got ce=%b %h cnt=%0d expected ce=%b %h cnt=%0d",
                             n, csum_err, dut_vec, good_cnt, bad, model_vec(exp_frame), exp_good);
      end
      idle(int'($urandom_range(4, 0)));
    end
  endtask

  task automatic test_back_to_back();
    frame_t f1, f2;
    int     seq[$];
    int     commits[$];
    logic   got[32];
    logic   want[32];
    f1 = random_frame();
    f2 = random_frame();
    send_partial(f1, 17, 0);
    seq.push_back(int'(model_sum(f1)));
    commits.push_back(0);
    seq.push_back(int'(SYNC));
    for (int i = 0; i < 17; i++) seq.push_back(int'(f2[i]));
    commits.push_back(seq.size());
    seq.push_back(int'(model_sum(f2)));
    for (int i = 0; i < 6; i++) seq.push_back(-1);
    for (int i = 0; i < seq.size(); i++) begin
      got[i]  = load_stb;
      want[i] = 1'b0;
      foreach (commits[c]) if (i > commits[c] && i <= commits[c] + STB_CYCLES) want[i] = 1'b1;
      rx_bus.rx_data  = (seq[i] >= 0) ? 8'(seq[i]) : 8'h00;
      rx_bus.rx_valid = (seq[i] >= 0);
      @(negedge clk);
    end
    rx_bus.rx_valid = 1'b0;
    exp_frame = f2;
    exp_good  = exp_good + 8'd2;
    for (int i = 0; i < seq.size(); i++) begin
      n_checks++;
      if (got[i] !== want[i]) begin
        n_errors++; $display("FAIL b2b_stb_cycle_%0d: got %b expected %b", i, got[i], want[i]);
      end
    end
    n_checks++;
    if (dut_vec !== model_vec(exp_frame) || good_cnt !== exp_good) begin
      n_errors++; $display("FAIL b2b_params: got %h cnt=%0d expected %h cnt=%0d",
                           dut_vec, good_cnt, model_vec(exp_frame), exp_good);
    end
    // Restart behaviour of the stretcher with triggers closer together than any two frames.
    for (int i = 0; i < 16; i++) begin
      got[i]  = s_stb;
      want[i] = ((i >= 1 && i <= 2 + STB_CYCLES) || (i >= 10 && i <= 9 + STB_CYCLES));
      s_trig  = (i == 0 || i == 2 || i == 9);
      @(negedge clk);
    end
    s_trig = 1'b0;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (got[i] !== want[i]) begin
        n_errors++; $display("FAIL stretch_restart_cycle_%0d: got %b expected %b", i, got[i], want[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    frame_t f;
    send_partial(plan_frame, 10, 0);
    reset = 1'b0;
    #1;
    n_checks++;
    if (dut_vec !== model_vec(reset_frame) || {load_stb, csum_err, tmo_err, good_cnt} !== 11'd0) begin
      n_errors++; $display("FAIL midreset_values: got %h stb=%b cnt=%0d expected %h stb=0 cnt=0",
                           dut_vec, load_stb, good_cnt, model_vec(reset_frame));
    end
    exp_frame = reset_frame;
    exp_good  = 8'd0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 10; i < 17; i++) send_byte(plan_frame[i]);
    send_byte(model_sum(plan_frame));
    idle(2);
    n_checks++;
    if (dut_vec !== model_vec(exp_frame) || good_cnt !== exp_good || csum_err !== 1'b0) begin
      n_errors++; $display("FAIL midreset_idle: got %h cnt=%0d expected %h cnt=%0d",
                           dut_vec, good_cnt, model_vec(exp_frame), exp_good);
    end
    f = random_frame();
    send_frame(f, model_sum(f), 1);
    exp_frame = f;
    exp_good  = exp_good + 8'd1;
    n_checks++;
    if (dut_vec !== model_vec(exp_frame) || good_cnt !== exp_good || load_stb !== 1'b1) begin
      n_errors++; $display("FAIL midreset_commit: got %h cnt=%0d stb=%b expected %h cnt=%0d stb=1",
                           dut_vec, good_cnt, load_stb, model_vec(exp_frame), exp_good);
    end
  endtask

  initial begin
    test_reset();
    test_bad_checksum();
    test_good_frame();
    test_timeout();
    test_garbage();
    test_random_frames();
    test_back_to_back();
    test_reset_mid_frame();
    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
